// File: rtl/depth_line_streamer.sv
// depth_line_streamer: ping-pong line buffer between the depth engines and an AXI4-Stream RGB video line.
module depth_line_streamer #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int MAX_ITER      = 200
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic                            line_start,
  input  logic                            line_done,
  input  logic                            we_in,
  input  logic [$clog2(SCREEN_WIDTH)-1:0] addr_in,
  input  logic [9:0]                      depth_in,
  output logic [23:0]                     m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            line_err
);
  localparam int AW = $clog2(SCREEN_WIDTH);
  localparam int YW = $clog2(SCREEN_HEIGHT);
  typedef enum logic [1:0] {F_REQ, F_FILL, F_HOLD} fill_t;
  typedef enum logic [1:0] {D_IDLE, D_RD, D_STREAM} drain_t;
  logic [1:0]    r_sync;
  logic          w_rst_n;
  fill_t         r_fs, w_fs_nx;
  drain_t        r_ds, w_ds_nx;
  logic          r_fill_bank, r_ld_q, r_line_start, r_line_err;
  logic [1:0]    r_full;
  logic [15:0]   r_cnt;
  logic [AW-1:0] r_x, w_rd_addr;
  logic [YW-1:0] r_y;
  logic [9:0]    r_q;
  logic [9:0]    r_mem [2][SCREEN_WIDTH];
  logic          w_drain_bank, w_wr, w_req, w_fill_end, w_swap;
  logic          w_start, w_hs, w_x_last, w_line_end;

  always_ff @(posedge clk or negedge reset)
    if (!reset) r_sync <= '0;
    else r_sync <= {r_sync[0], 1'b1};

  assign w_rst_n = r_sync[1];

  always_comb begin
    w_drain_bank = ~r_fill_bank;
    w_req        = r_fs == F_REQ && !r_full[r_fill_bank];
    w_fill_end   = r_fs == F_FILL && line_done && !r_ld_q;
    w_swap       = r_fs == F_HOLD && !r_full[w_drain_bank];
    w_wr         = r_fs == F_FILL && we_in && ({1'b0, addr_in} < (AW+1)'(SCREEN_WIDTH));
    w_fs_nx      = w_req ? F_FILL : w_fill_end ? F_HOLD : w_swap ? F_REQ : r_fs;
    w_hs         = m_axis_tvalid && m_axis_tready;
    w_x_last     = r_x == AW'(SCREEN_WIDTH - 1);
    w_line_end   = w_hs && w_x_last;
    w_start      = r_ds == D_IDLE && r_full[w_drain_bank];
    w_ds_nx      = w_start ? D_RD : r_ds == D_RD ? D_STREAM : w_line_end ? D_IDLE : r_ds;
    // Read one ahead on a handshake, otherwise re-read the presented pixel so a stall holds tdata.
    w_rd_addr    = (w_hs && !w_x_last) ? r_x + 1'b1 : r_x;
  end

  always_ff @(posedge clk or negedge w_rst_n)
    if (!w_rst_n) begin
      r_fs         <= F_REQ;
      r_ds         <= D_IDLE;
      r_ld_q       <= 1'b0;
      r_line_start <= 1'b0;
      r_line_err   <= 1'b0;
      r_cnt        <= '0;
      r_fill_bank  <= 1'b0;
      r_full       <= '0;
      r_x          <= '0;
      r_y          <= '0;
    end else begin
      r_fs         <= w_fs_nx;
      r_ds         <= w_ds_nx;
      r_ld_q       <= line_done;
      r_line_start <= w_req;
      r_line_err   <= r_line_err | (w_fill_end && r_cnt != 16'(SCREEN_WIDTH));
      r_cnt        <= w_req ? '0 : (w_wr && r_cnt != '1) ? r_cnt + 16'd1 : r_cnt;
      r_fill_bank  <= r_fill_bank ^ w_swap;
      r_full       <= (r_full | ({1'b0, w_fill_end} << r_fill_bank)) & ~({1'b0, w_line_end} << w_drain_bank);
      r_x          <= (w_start || w_line_end) ? '0 : w_hs ? r_x + 1'b1 : r_x;
      r_y          <= !w_line_end ? r_y : (r_y == YW'(SCREEN_HEIGHT - 1)) ? '0 : r_y + 1'b1;
    end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_fill_bank][addr_in] <= depth_in;
    r_q <= r_mem[w_drain_bank][w_rd_addr];
  end

  assign line_start    = r_line_start;
  assign line_err      = r_line_err;
  assign m_axis_tvalid = r_ds == D_STREAM;
  assign m_axis_tuser  = m_axis_tvalid && r_x == '0 && r_y == '0;
  assign m_axis_tlast  = m_axis_tvalid && w_x_last;
  assign m_axis_tdata  = (!m_axis_tvalid || r_q >= 10'(MAX_ITER)) ? '0 :
                         {r_q[7:0], r_q[6:0], 1'b0, 8'hFF - r_q[7:0]};
endmodule

// File: tb/tb_depth_line_streamer.sv
// tb_depth_line_streamer: table vectors plus random lines checked against a line-level model of the streamer.
module tb_depth_line_streamer;
  localparam int W  = 640;
  localparam int H  = 4;
  localparam int MI = 200;
  typedef struct packed {logic [23:0] data; logic user; logic last;} beat_t;
  typedef struct {int x; logic [9:0] depth; logic [23:0] rgb;} vec_t;

  logic        clk = 0;
  logic        reset = 1;
  logic        line_start, line_done = 0, we_in = 0;
  logic [9:0]  addr_in = 0, depth_in = 0;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready = 1, m_axis_tuser, m_axis_tlast, line_err;

  int    errs = 0, checks = 0, ls_count = 0, ls_used = 0;
  int    beats_total = 0, beat_in_line = 0, n_user = 0, n_lines = 0, mode = 1;
  bit    stalled = 0, mdl_err = 0;
  beat_t held, got, exp_b;
  beat_t exp_q[$];
  logic [23:0] rx_line [W];
  logic [9:0]  mdl_mem [2][W];
  vec_t  tbl [8];

  depth_line_streamer #(.SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .MAX_ITER(MI)) dut (
    .clk(clk), .reset(reset), .line_start(line_start), .line_done(line_done),
    .we_in(we_in), .addr_in(addr_in), .depth_in(depth_in),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .line_err(line_err)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] colour(input logic [9:0] d);
    int r, g, b;
    if (d >= MI) return 24'h0;
    r = d % 256;
    g = (2 * d) % 256;
    b = 255 - r;
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    m_axis_tready = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
  end

  always @(negedge clk) begin
    got = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
    if (line_start) ls_count++;
    if (stalled) begin
      chk("stall_tvalid", 32'(m_axis_tvalid), 1);
      if (m_axis_tvalid) chk("stall_hold", 32'(got), 32'(held));
    end
    stalled = m_axis_tvalid && !m_axis_tready;
    held = got;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() != 0) exp_b = exp_q.pop_front();
      else exp_b = '1;
      chk("beat", 32'(got), 32'(exp_b));
      beats_total++;
      if (m_axis_tuser) n_user++;
      if (beat_in_line < W) rx_line[beat_in_line] = m_axis_tdata;
      beat_in_line = m_axis_tlast ? 0 : beat_in_line + 1;
    end
  end

  task automatic do_reset();
    reset = 0;
    stalled = 0;
    exp_q.delete();
    n_lines = 0;
    mdl_err = 0;
    beat_in_line = 0;
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 0);
    chk("rst_tdata", 32'(m_axis_tdata), 0);
    chk("rst_tuser", 32'(m_axis_tuser), 0);
    chk("rst_tlast", 32'(m_axis_tlast), 0);
    chk("rst_line_start", 32'(line_start), 0);
    chk("rst_line_err", 32'(line_err), 0);
    repeat (3) @(posedge clk);
    #1;
    ls_used = ls_count;
    reset = 1;
    @(posedge clk); #1; chk("ls_rel1", 32'(line_start), 0);
    @(posedge clk); #1; chk("ls_rel2", 32'(line_start), 0);
    @(posedge clk); #1; chk("ls_rel3", 32'(line_start), 1);
    @(posedge clk); #1; chk("ls_rel4", 32'(line_start), 0);
  endtask

  task automatic fill_line(input bit use_tbl, input bit bad);
    int b = 0;
    int cnt = 0;
    int bank, a;
    logic [9:0] d;
    while (ls_count == ls_used && b < 4000) begin
      @(posedge clk);
      b++;
    end
    chk("line_start_seen", 32'(ls_count != ls_used), 1);
    if (ls_count != ls_used) ls_used++;
    @(posedge clk);
    #1;
    bank = n_lines % 2;
    for (int x = 0; x < W; x++) begin
      a = (bad && x == W - 1) ? 700 : x;
      d = ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, MI - 1)) : 10'($urandom_range(0, 1023));
      if (use_tbl) for (int k = 0; k < 8; k++) if (tbl[k].x == x) d = tbl[k].depth;
      we_in = 1;
      addr_in = 10'(a);
      depth_in = d;
      if (a < W) begin
        mdl_mem[bank][a] = d;
        cnt++;
      end
      @(posedge clk);
      #1;
    end
    we_in = 0;
    line_done = 1;
    @(posedge clk);
    #1;
    line_done = 0;
    if (cnt != W) mdl_err = 1;
    for (int x = 0; x < W; x++)
      exp_q.push_back(beat_t'{colour(mdl_mem[bank][x]), x == 0 && n_lines % H == 0, x == W - 1});
    n_lines++;
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q.size() != 0 || m_axis_tvalid) && b < 5000) begin
      @(posedge clk);
      b++;
    end
    chk("drain_done", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    tbl[0] = '{0,     10'd0,    24'h0000FF};
    tbl[1] = '{1,     10'd1,    24'h0102FE};
    tbl[2] = '{2,     10'd127,  24'h7FFE80};
    tbl[3] = '{3,     10'd128,  24'h80007F};
    tbl[4] = '{4,     10'd199,  24'hC78E38};
    tbl[5] = '{5,     10'd200,  24'h000000};
    tbl[6] = '{6,     10'd1023, 24'h000000};
    tbl[7] = '{W - 1, 10'd100,  24'h64C89B};
    @(posedge clk);
    #1;
    do_reset();
    fill_line(1, 0);
    wait_drain();
    for (int k = 0; k < 8; k++) chk("tbl_rgb", 32'(rx_line[tbl[k].x]), 32'(tbl[k].rgb));
    chk("line_err_line0", 32'(line_err), 32'(mdl_err));
    mode = 0;
    fill_line(0, 0);
    fill_line(0, 0);
    repeat (200) @(posedge clk);
    #1;
    chk("no_third_ls", ls_count - ls_used, 0);
    chk("stalled_tvalid", 32'(m_axis_tvalid), 1);
    chk("beats_before_release", beats_total, W);
    mode = 1;
    b = 0;
    while (ls_count == ls_used && b < 3000) begin
      @(posedge clk);
      b++;
    end
    chk("third_ls", 32'(ls_count != ls_used), 1);
    chk("line1_drained_first", beats_total, 2 * W);
    #1;
    mode = 2;
    fill_line(0, 0);
    fill_line(0, 0);
    wait_drain();
    chk("tuser_count_wrap", n_user, 2);
    chk("line_err_clean", 32'(line_err), 32'(mdl_err));
    mode = 1;
    fill_line(0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("line_err_short", 32'(line_err), 32'(mdl_err));
    chk("line_err_set", 32'(line_err), 1);
    wait_drain();
    chk("stale_639", 32'(rx_line[W - 1]), 32'(colour(mdl_mem[1][W - 1])));
    fill_line(0, 0);
    b = 0;
    while (beat_in_line < 300 && b < 5000) begin
      @(posedge clk);
      b++;
    end
    chk("reach_beat_300", 32'(beat_in_line >= 300), 1);
    #1;
    do_reset();
    fill_line(0, 0);
    wait_drain();
    chk("tuser_after_reset", n_user, 3);
    chk("line_err_after_reset", 32'(line_err), 32'(mdl_err));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
